// File: rtl/mem_wb_stage.sv
// MEM/WB back end of the pipeline: EX/MEM latch, byte-wide data memory with
// a preload port, EX/MEM -> EX operand forwarding, MEM/WB latch and a
// saturating retired-instruction counter.
module mem_wb_stage #(
    parameter int MEM_DEPTH = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       ALU_Result,
    input  logic             ALU_ctrl_ex,
    input  logic             RegWrite_ex,
    input  logic [2:0]       Rd_ex,
    input  logic             Flush,
    input  logic [2:0]       Rs1_ex,
    input  logic [2:0]       Rs2_ex,
    input  logic             Pre_we,
    input  logic [7:0]       Pre_addr,
    input  logic [7:0]       Pre_data,
    output logic [7:0]       Forwarded_reg,
    output logic             Forward_Rs1,
    output logic             Forward_Rs2,
    output logic [7:0]       WB_data,
    output logic [2:0]       WB_rd,
    output logic             WB_en,
    output logic [CNT_W-1:0] Retire_count
);

    // Number of address bits that select a byte; upper address bits wrap.
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Byte index inside the memory: low address bits only.
    function automatic logic [IDX_W-1:0] mem_index(input logic [7:0] addr);
        return addr[IDX_W-1:0];
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [7:0]       mem_r [MEM_DEPTH];
    logic [7:0]       exm_alu_r;
    logic             exm_ctrl_r;
    logic [2:0]       exm_rd_r;
    logic             exm_valid_r;
    logic [CNT_W-1:0] retire_r;

    logic             ex_valid_s;
    logic [7:0]       mem_out_s;
    logic [7:0]       mem_val_s;
    logic             pre_addr_unused_s;

    // Only the low index bits of the preload address select a byte.
    assign pre_addr_unused_s = ^Pre_addr;

    // x0 is hard-wired: a write to it never becomes a valid instruction.
    assign ex_valid_s = RegWrite_ex & (Rd_ex != 3'd0) & ~Flush;

    // Combinational read: a same-edge preload write is not yet visible here.
    assign mem_out_s = mem_r[mem_index(exm_alu_r)];

    assign Retire_count = retire_r;

    // Preload write port; memory contents survive reset by design.
    always_ff @(posedge clk) begin
        if (Pre_we) begin
            mem_r[mem_index(Pre_addr)] <= Pre_data;
        end
    end

    // EX/MEM latch: capture the instruction leaving EX, bubbling flushed ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exm_alu_r   <= 8'h00;
            exm_ctrl_r  <= 1'b0;
            exm_rd_r    <= 3'd0;
            exm_valid_r <= 1'b0;
        end else begin
            exm_alu_r   <= ALU_Result;
            exm_ctrl_r  <= ALU_ctrl_ex;
            exm_rd_r    <= Rd_ex;
            exm_valid_r <= ex_valid_s;
        end
    end

    // MEM-stage result: loaded byte for loads, the ALU value for moves.
    always_comb begin
        mem_val_s = 8'h00;
        if (exm_ctrl_r) begin
            mem_val_s = exm_alu_r;
        end else begin
            mem_val_s = mem_out_s;
        end
    end

    // Forwarding from EX/MEM to the instruction currently in EX.
    always_comb begin
        Forward_Rs1   = 1'b0;
        Forward_Rs2   = 1'b0;
        Forwarded_reg = 8'h00;
        if (exm_valid_r) begin
            Forward_Rs1   = (exm_rd_r == Rs1_ex);
            Forward_Rs2   = (exm_rd_r == Rs2_ex);
            Forwarded_reg = mem_val_s;
        end else begin
            Forward_Rs1   = 1'b0;
            Forward_Rs2   = 1'b0;
            Forwarded_reg = 8'h00;
        end
    end

    // MEM/WB latch driving the register-file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_data <= 8'h00;
            WB_rd   <= 3'd0;
            WB_en   <= 1'b0;
        end else begin
            WB_data <= mem_val_s;
            WB_rd   <= exm_rd_r;
            WB_en   <= exm_valid_r;
        end
    end

    // Count retirements (cycles with WB_en high), saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_r <= {CNT_W{1'b0}};
        end else if (WB_en) begin
            retire_r <= sat_inc(retire_r);
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised scoreboard bench for mem_wb_stage with a cycle-level reference
// model: an instruction issued in cycle t forwards in cycle t+1 and writes
// back in cycle t+2; memory is a plain array indexed modulo the depth.
module tb_mem_wb_stage;

    localparam int DEPTH = 64;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    ALU_Result = 8'h00;
    logic          ALU_ctrl_ex = 1'b0;
    logic          RegWrite_ex = 1'b0;
    logic [2:0]    Rd_ex = 3'd0;
    logic          Flush = 1'b0;
    logic [2:0]    Rs1_ex = 3'd0;
    logic [2:0]    Rs2_ex = 3'd0;
    logic          Pre_we = 1'b0;
    logic [7:0]    Pre_addr = 8'h00;
    logic [7:0]    Pre_data = 8'h00;
    logic [7:0]    Forwarded_reg;
    logic          Forward_Rs1;
    logic          Forward_Rs2;
    logic [7:0]    WB_data;
    logic [2:0]    WB_rd;
    logic          WB_en;
    logic [CW-1:0] Retire_count;

    always #5 clk = ~clk;

    mem_wb_stage #(.MEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALU_Result(ALU_Result), .ALU_ctrl_ex(ALU_ctrl_ex),
        .RegWrite_ex(RegWrite_ex), .Rd_ex(Rd_ex), .Flush(Flush),
        .Rs1_ex(Rs1_ex), .Rs2_ex(Rs2_ex),
        .Pre_we(Pre_we), .Pre_addr(Pre_addr), .Pre_data(Pre_data),
        .Forwarded_reg(Forwarded_reg), .Forward_Rs1(Forward_Rs1),
        .Forward_Rs2(Forward_Rs2), .WB_data(WB_data), .WB_rd(WB_rd),
        .WB_en(WB_en), .Retire_count(Retire_count)
    );

    typedef struct {
        logic       valid;
        logic       ctrl;
        logic [7:0] alu;
        logic [2:0] rd;
    } inst_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] rd;
    } wb_t;

    typedef struct {
        logic          f1;
        logic          f2;
        logic [7:0]    freg;
        logic          wb_en;
        logic [CW-1:0] cnt;
    } cyc_t;

    wb_t        wb_q[$];
    cyc_t       cyc_q[$];
    logic [7:0] mem_m [DEPTH];
    inst_t      in_mem;
    logic       in_wb_valid;
    int         retired;
    logic       mon_en = 1'b0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] result_of(input inst_t i);
        if (i.ctrl) return i.alu;
        return mem_m[int'(i.alu) % DEPTH];
    endfunction

    function automatic void model_reset();
        in_mem      = '{valid: 1'b0, ctrl: 1'b0, alu: 8'h00, rd: 3'd0};
        in_wb_valid = 1'b0;
        retired     = 0;
    endfunction

    // Drive one EX-stage cycle, record what the DUT must show during it,
    // then advance the model across the next rising edge.
    task automatic step(input logic ctrl, input logic [7:0] alu, input logic rw,
                        input logic [2:0] rd, input logic fl,
                        input logic [2:0] r1, input logic [2:0] r2,
                        input logic pwe, input logic [7:0] pa, input logic [7:0] pd);
        cyc_t       e;
        logic [7:0] v;
        ALU_ctrl_ex = ctrl; ALU_Result = alu; RegWrite_ex = rw; Rd_ex = rd;
        Flush = fl; Rs1_ex = r1; Rs2_ex = r2;
        Pre_we = pwe; Pre_addr = pa; Pre_data = pd;
        v       = result_of(in_mem);
        e.f1    = in_mem.valid && (in_mem.rd == r1);
        e.f2    = in_mem.valid && (in_mem.rd == r2);
        e.freg  = in_mem.valid ? v : 8'h00;
        e.wb_en = in_wb_valid;
        e.cnt   = CW'((retired > MAXC) ? MAXC : retired);
        cyc_q.push_back(e);
        if (in_mem.valid) wb_q.push_back('{data: v, rd: in_mem.rd});
        retired     = retired + (in_wb_valid ? 1 : 0);
        in_wb_valid = in_mem.valid;
        in_mem      = '{valid: rw && (rd != 3'd0) && !fl, ctrl: ctrl, alu: alu, rd: rd};
        if (pwe) mem_m[int'(pa) % DEPTH] = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wb_data"}, 32'(WB_data), 32'h0);
        chk({tag, "_wb_rd"},   32'(WB_rd),   32'h0);
        chk({tag, "_wb_en"},   32'(WB_en),   32'h0);
        chk({tag, "_fwd1"},    32'(Forward_Rs1), 32'h0);
        chk({tag, "_fwd2"},    32'(Forward_Rs2), 32'h0);
        chk({tag, "_freg"},    32'(Forwarded_reg), 32'h0);
        chk({tag, "_retire"},  32'(Retire_count), 32'h0);
    endtask

    // Monitor: per-cycle expectations every cycle, writebacks whenever WB_en shows.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cyc_q.size() > 0) begin
                cyc_t c;
                c = cyc_q.pop_front();
                chk("fwd_rs1", 32'(Forward_Rs1), 32'(c.f1));
                chk("fwd_rs2", 32'(Forward_Rs2), 32'(c.f2));
                chk("fwd_reg", 32'(Forwarded_reg), 32'(c.freg));
                chk("wb_en", 32'(WB_en), 32'(c.wb_en));
                chk("retire_count", 32'(Retire_count), 32'(c.cnt));
            end
            if (WB_en) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 32'(WB_en), 32'h0);
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    chk("wb_data", 32'(WB_data), 32'(w.data));
                    chk("wb_rd", 32'(WB_rd), 32'(w.rd));
                end
            end
        end
    end

    initial begin
        logic [7:0] last_alu;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Fill memory so every byte has a known value.
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 8'(a), 8'($urandom));
        end

        // Directed: preloaded load, move forwarding, x0, wrap + same-cycle preload, flush.
        step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 8'h05, 8'h3C);
        step(1'b0, 8'h05, 1'b1, 3'd2, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 8'h7F, 1'b1, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd3, 3'd3, 1'b0, 8'h00, 8'h00);
        step(1'b1, 8'h44, 1'b1, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 8'h05, 8'hA1);
        step(1'b0, 8'h45, 1'b1, 3'd4, 1'b0, 3'd4, 3'd0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h45, 1'b1, 3'd5, 1'b0, 3'd0, 3'd4, 1'b1, 8'h05, 8'h11);
        bubble();
        step(1'b1, 8'h22, 1'b1, 3'd1, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 8'h33, 1'b1, 3'd2, 1'b1, 3'd1, 3'd1, 1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2, 1'b0, 8'h00, 8'h00);
        repeat (3) bubble();

        // Random traffic, preloads often aimed at the address now in MEM.
        last_alu = 8'h00;
        for (int n = 0; n < 300; n++) begin
            logic [7:0] alu;
            logic [7:0] pa;
            alu = 8'($urandom);
            pa  = ($urandom_range(0, 1) == 0) ? last_alu : 8'($urandom);
            step(1'($urandom_range(0, 1)), alu, ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0), pa, 8'($urandom));
            last_alu = alu;
        end
        repeat (3) bubble();
        chk("wb_queue_drained", 32'(wb_q.size()), 32'h0);

        // Mid-cycle reset with instructions in flight and forwarding active.
        step(1'b1, 8'h55, 1'b1, 3'd6, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 8'h66, 1'b1, 3'd7, 1'b0, 3'd6, 3'd6, 1'b0, 8'h00, 8'h00);
        mon_en = 1'b0;
        cyc_q.delete();
        wb_q.delete();
        Rs1_ex = 3'd7;
        Rs2_ex = 3'd7;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        @(posedge clk);
        #1 chk_all_zero("held_reset");
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Twenty retirements drive the 4-bit counter into saturation.
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 8'($urandom), 1'b1, 3'($urandom_range(1, 7)), 1'b0,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, 8'h00, 8'h00);
        end
        repeat (3) bubble();
        chk("retire_saturated", 32'(Retire_count), 32'h0000000F);
        chk("wb_queue_final", 32'(wb_q.size()), 32'h0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
